lfsr_gen: RTL and testbench

//  Parametrised Fibonacci LFSR: the generalised successor of our 1-bit seeded practice shifter.

---
 rtl/lfsr_pkg.sv | 82 ++++++++
 rtl/lfsr_gen.sv | 106 ++++++++++
 tb/tb_lfsr_gen.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR helpers: maximal-length default tap masks (widths 4..32) and the
// Fibonacci next-state function used by lfsr_gen.
package lfsr_pkg;

    // Mask bit i selects state[i] into the feedback XOR.
    localparam logic [31:0] TAPS_W4  = 32'h0000_000C;
    localparam logic [31:0] TAPS_W5  = 32'h0000_0014;
    localparam logic [31:0] TAPS_W6  = 32'h0000_0030;
    localparam logic [31:0] TAPS_W7  = 32'h0000_0060;
    localparam logic [31:0] TAPS_W8  = 32'h0000_00B8;
    localparam logic [31:0] TAPS_W9  = 32'h0000_0110;
    localparam logic [31:0] TAPS_W10 = 32'h0000_0240;
    localparam logic [31:0] TAPS_W11 = 32'h0000_0500;
    localparam logic [31:0] TAPS_W12 = 32'h0000_0829;
    localparam logic [31:0] TAPS_W13 = 32'h0000_100D;
    localparam logic [31:0] TAPS_W14 = 32'h0000_2015;
    localparam logic [31:0] TAPS_W15 = 32'h0000_6000;
    localparam logic [31:0] TAPS_W16 = 32'h0000_D008;
    localparam logic [31:0] TAPS_W17 = 32'h0001_2000;
    localparam logic [31:0] TAPS_W18 = 32'h0002_0400;
    localparam logic [31:0] TAPS_W19 = 32'h0004_0023;
    localparam logic [31:0] TAPS_W20 = 32'h0009_0000;
    localparam logic [31:0] TAPS_W21 = 32'h0014_0000;
    localparam logic [31:0] TAPS_W22 = 32'h0030_0000;
    localparam logic [31:0] TAPS_W23 = 32'h0042_0000;
    localparam logic [31:0] TAPS_W24 = 32'h00E1_0000;
    localparam logic [31:0] TAPS_W25 = 32'h0120_0000;
    localparam logic [31:0] TAPS_W26 = 32'h0200_0023;
    localparam logic [31:0] TAPS_W27 = 32'h0400_0013;
    localparam logic [31:0] TAPS_W28 = 32'h0900_0000;
    localparam logic [31:0] TAPS_W29 = 32'h1400_0000;
    localparam logic [31:0] TAPS_W30 = 32'h2000_0029;
    localparam logic [31:0] TAPS_W31 = 32'h4800_0000;
    localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

    function automatic logic [31:0] default_taps(input int width);
        logic [31:0] t;
        t = TAPS_W4;
        case (width)
            5:  t = TAPS_W5;
            6:  t = TAPS_W6;
            7:  t = TAPS_W7;
            8:  t = TAPS_W8;
            9:  t = TAPS_W9;
            10: t = TAPS_W10;
            11: t = TAPS_W11;
            12: t = TAPS_W12;
            13: t = TAPS_W13;
            14: t = TAPS_W14;
            15: t = TAPS_W15;
            16: t = TAPS_W16;
            17: t = TAPS_W17;
            18: t = TAPS_W18;
            19: t = TAPS_W19;
            20: t = TAPS_W20;
            21: t = TAPS_W21;
            22: t = TAPS_W22;
            23: t = TAPS_W23;
            24: t = TAPS_W24;
            25: t = TAPS_W25;
            26: t = TAPS_W26;
            27: t = TAPS_W27;
            28: t = TAPS_W28;
            29: t = TAPS_W29;
            30: t = TAPS_W30;
            31: t = TAPS_W31;
            32: t = TAPS_W32;
            default: t = TAPS_W4;
        endcase
        return t;
    endfunction

    // Shift left, feedback parity into bit 0, clip to the active width.
    function automatic logic [31:0] lfsr_next(input logic [31:0] state,
                                              input logic [31:0] taps,
                                              input int          width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return {state[30:0], ^(state & taps)} & mask;
    endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, zero-seed rejection and lock-up guard.
// Define LFSR_PERIOD_EN to add last-seed tracking, the wrap pulse and period_cnt.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH      = 4,
    parameter logic [WIDTH-1:0] TAPS       = WIDTH'(4'b1001),
    parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic             out,
    output logic [WIDTH-1:0] state,
    output logic             zero_seed,
    output logic             wrap,
    output logic [WIDTH-1:0] period_cnt
);

    logic [WIDTH-1:0] state_q, state_d;
    logic             zero_seed_q, zero_seed_d;
    logic [WIDTH-1:0] step_val;
    logic             seed_ok;
    logic             state_zero;

    assign step_val   = WIDTH'(lfsr_next(32'(state_q), 32'(TAPS), WIDTH));
    assign seed_ok    = (seed != '0);
    assign state_zero = (state_q == '0);

    // Priority: load, then lock-up recovery, then step, else hold.
    always_comb begin
        state_d     = state_q;
        zero_seed_d = 1'b0;
        if (load) begin
            if (seed_ok) begin
                state_d = seed;
            end else begin
                state_d     = RESET_SEED;
                zero_seed_d = 1'b1;
            end
        end else if (state_zero) begin
            state_d = RESET_SEED;
        end else if (ena) begin
            state_d = step_val;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RESET_SEED;
            zero_seed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            zero_seed_q <= zero_seed_d;
        end
    end

    assign state     = state_q;
    assign out       = state_q[WIDTH-1];
    assign zero_seed = zero_seed_q;

`ifdef LFSR_PERIOD_EN
    logic [WIDTH-1:0] last_seed_q, last_seed_d;
    logic [WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic             wrap_q, wrap_d;

    // A lock-up recovery is not a step, so the period count is left alone.
    always_comb begin
        last_seed_d  = last_seed_q;
        period_cnt_d = period_cnt_q;
        wrap_d       = 1'b0;
        if (load) begin
            last_seed_d  = seed_ok ? seed : RESET_SEED;
            period_cnt_d = '0;
        end else if (!state_zero && ena) begin
            if (step_val == last_seed_q) begin
                wrap_d       = 1'b1;
                period_cnt_d = '0;
            end else begin
                period_cnt_d = period_cnt_q + WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_seed_q  <= RESET_SEED;
            period_cnt_q <= '0;
            wrap_q       <= 1'b0;
        end else begin
            last_seed_q  <= last_seed_d;
            period_cnt_q <= period_cnt_d;
            wrap_q       <= wrap_d;
        end
    end

    assign wrap       = wrap_q;
    assign period_cnt = period_cnt_q;
`else
    assign wrap       = 1'b0;
    assign period_cnt = '0;
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed self-checking bench for lfsr_gen (WIDTH=4, TAPS=1001, RESET_SEED=0001).
`timescale 1ns/1ps
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       load;
    logic [3:0] seed;
    logic       out;
    logic [3:0] state;
    logic       zero_seed;
    logic       wrap;
    logic [3:0] period_cnt;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef LFSR_PERIOD_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    always #5 clk = ~clk;

    lfsr_gen #(
        .WIDTH      (4),
        .TAPS       (4'b1001),
        .RESET_SEED (4'b0001)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ena        (ena),
        .load       (load),
        .seed       (seed),
        .out        (out),
        .state      (state),
        .zero_seed  (zero_seed),
        .wrap       (wrap),
        .period_cnt (period_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] pc(input logic [3:0] v);
        return PEN ? v : 4'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        $display("t=%0t load=%b ena=%b seed=%b -> state=%b out=%b zs=%b wrap=%b cnt=%0d",
                 $time, load, ena, seed, state, out, zero_seed, wrap, period_cnt);
    endtask

    logic [3:0]  seq [15] = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
                              4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};
    logic [15:0] seen;

    initial begin
        rst = 1'b0; ena = 1'b0; load = 1'b0; seed = 4'h0;
        #2 rst = 1'b1;
        #1;
        chk("rst_state", 32'(state), 32'h1);
        chk("rst_zs", 32'(zero_seed), 32'h0);
        tick();
        #2 rst = 1'b0;

        // Run a little, then hit reset mid-cycle for 1 ns
        ena = 1'b1;
        tick();
        tick();
        chk("pre_rst_state", 32'(state), 32'h7);
        ena = 1'b0;
        rst = 1'b1;
        #1;
        chk("t1_state", 32'(state), 32'h1);
        chk("t1_out", 32'(out), 32'h0);
        chk("t1_zs", 32'(zero_seed), 32'h0);
        chk("t1_wrap", 32'(wrap), 32'h0);
        chk("t1_cnt", 32'(period_cnt), 32'h0);
        rst = 1'b0;

        // Three steps from the reset seed
        chk("t2_out0", 32'(out), 32'h0);
        ena = 1'b1;
        tick();
        chk("t2_s1", 32'(state), 32'h3);
        chk("t2_out1", 32'(out), 32'h0);
        chk("t2_cnt1", 32'(period_cnt), 32'(pc(4'd1)));
        tick();
        chk("t2_s2", 32'(state), 32'h7);
        chk("t2_out2", 32'(out), 32'h0);
        tick();
        chk("t2_s3", 32'(state), 32'hF);
        chk("t2_out3", 32'(out), 32'h1);
        chk("t2_cnt3", 32'(period_cnt), 32'(pc(4'd3)));

        // Full period from 0001
        ena = 1'b0; load = 1'b1; seed = 4'h1;
        tick();
        chk("t3_load", 32'(state), 32'h1);
        chk("t3_load_cnt", 32'(period_cnt), 32'h0);
        load = 1'b0; ena = 1'b1;
        seen = '0;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("t3_state", 32'(state), 32'(seq[i]));
            chk("t3_wrap", 32'(wrap), (i == 14) ? 32'(PEN) : 32'h0);
            chk("t3_cnt", 32'(period_cnt), (i == 14) ? 32'h0 : 32'(pc(4'(i + 1))));
            seen[state] = 1'b1;
        end
        chk("t3_visited", 32'(seen), 32'hFFFE);
        ena = 1'b0;
        tick();
        chk("t3_wrap_end", 32'(wrap), 32'h0);
        chk("t3_hold", 32'(state), 32'h1);

        // Zero seed rejected, then a normal load
        load = 1'b1; seed = 4'h0;
        tick();
        chk("t4_zstate", 32'(state), 32'h1);
        chk("t4_zs_hi", 32'(zero_seed), 32'h1);
        seed = 4'hA;
        tick();
        chk("t4_state", 32'(state), 32'hA);
        chk("t4_zs_lo", 32'(zero_seed), 32'h0);
        chk("t4_cnt", 32'(period_cnt), 32'h0);

        // load beats ena, then hold
        load = 1'b1; ena = 1'b1; seed = 4'h6;
        tick();
        chk("t5_load", 32'(state), 32'h6);
        load = 1'b0; ena = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_hold", 32'(state), 32'h6);
        end
        ena = 1'b1;
        tick();
        chk("t5_step", 32'(state), 32'hC);
        chk("t5_cnt", 32'(period_cnt), 32'(pc(4'd1)));

        // Lock-up guard: corrupt the register, expect recovery without ena
        ena = 1'b0;
        force dut.state_q = 4'h0;
        #1;
        release dut.state_q;
        #1;
        chk("t6_forced", 32'(state), 32'h0);
        tick();
        chk("t6_recover", 32'(state), 32'h1);
        chk("t6_wrap", 32'(wrap), 32'h0);
        chk("t6_cnt", 32'(period_cnt), 32'(pc(4'd1)));
        chk("t6_zs", 32'(zero_seed), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
